param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 119 +++++++++++
 tb/tb_param_sync_fifo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: synchronous FIFO with occupancy and sticky error flags.
// Compile-time option: define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module param_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      din,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      dout,
    output logic                   dout_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_accept, rd_accept;

    // Handshake: wr_en/rd_en are requests; a transfer happens only when the request
    // is high and the opposing flag (full for writes, empty for reads) is low.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_accept && !rd_accept) count_d = count_q + CW'(1);
        if (rd_accept && !wr_accept) count_d = count_q - CW'(1);
        // A new error event outranks a same-cycle clear.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full)  overflow_d  = 1'b1;
        if (rd_en && empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) mem_q[wr_ptr_q] <= din;
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign dout       = mem_q[rd_ptr_q];
    assign dout_valid = !empty;
`else
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = rd_accept;
        if (rd_accept) dout_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Testbench for param_sync_fifo: directed scenarios plus random traffic against a queue model.
// Honors PARAM_SYNC_FIFO_FWFT_EN to match the DUT read mode.
module tb_param_sync_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid, full, empty, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;
  logic [DW-1:0] exp_dout = '0;
  logic          exp_valid = 1'b0;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge's worth of the FIFO rules to the queue model.
  task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r,
                            input logic c, input logic rs);
    logic was_full, was_empty;
    if (rs) begin
      exp_q.delete();
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
      exp_dout  = '0;
      exp_valid = 1'b0;
      return;
    end
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    exp_valid = 1'b0;
    if (r && !was_empty) begin
      exp_dout  = exp_q.pop_front();
      exp_valid = 1'b1;
    end
    if (w && !was_full) exp_q.push_back(d);
    if (c) begin
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end
    if (w && was_full)  exp_ovf = 1'b1;
    if (r && was_empty) exp_udf = 1'b1;
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    check("count", 64'(count), 64'(n));
    check("full", 64'(full), 64'(n == DEPTH));
    check("empty", 64'(empty), 64'(n == 0));
    check("almost_full", 64'(almost_full), 64'(n >= AF));
    check("almost_empty", 64'(almost_empty), 64'(n <= AE));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("underflow", 64'(underflow), 64'(exp_udf));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    check("dout_valid", 64'(dout_valid), 64'(n != 0));
    if (n != 0) check("dout", 64'(dout), 64'(exp_q[0]));
`else
    check("dout_valid", 64'(dout_valid), 64'(exp_valid));
    check("dout", 64'(dout), 64'(exp_dout));
`endif
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c = 1'b0, input logic rs = 1'b0);
    wr_en = w; din = d; rd_en = r; clr_err = c; rst = rs;
    @(posedge clk);
    model_edge(w, d, r, c, rs);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] wd;
    // Reset state
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Basic write/read order
    for (int i = 0; i < 4; i++) step(1'b1, DW'(32'hA1 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    idle();

    // Fill to full, then overflow attempt with 0xFF
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i + 1), 1'b0);
    step(1'b1, DW'(32'hFF), 1'b0);
    idle();
    // Full with simultaneous read and write: write rejected
    step(1'b1, DW'(32'h77), 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    // Refill, then overflow event coinciding with clear: set wins
    step(1'b1, DW'(32'h88), 1'b0);
    step(1'b1, DW'(32'h99), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    // Drain and underflow
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1);
    idle();

    // Streaming with 3 primed words; pointers wrap repeatedly
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, DW'(i), 1'b0);
    for (int i = 3; i < 43; i++) step(1'b1, DW'(i), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Mid-stream reset with count=7 and underflow set
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, DW'(32'hC0 + i), 1'b0);
    step(1'b1, DW'(32'hEE), 1'b1, 1'b0, 1'b1);
    step(1'b1, DW'(32'h5A), 1'b0);
    idle();
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Randomised traffic: write-biased then read-biased phases
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i < 300) ? 70 : 30;
      wd = $urandom();
      step(1'($urandom_range(0, 99) < wp), wd,
           1'($urandom_range(0, 99) < (100 - wp)),
           1'($urandom_range(0, 99) < 5),
           1'($urandom_range(0, 299) == 0));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
